aer_reset_gen: RTL

- Multi-channel, multi-mode AER reset generator; successor to the single-channel reset timer.
- Each channel drives one active-low AER reset from one of four sources: regfile passthrough, free-running periodic timer, triggered one-shot, or forced reset.
- Pulse width is programmable. Timer thresholds are per channel.
- Sits between the register file and the AER pixel-array reset inputs.

---
 rtl/aer_pkg.sv | 28 ++
 rtl/aer_reset_chan.sv | 156 +++++++++++++++
 rtl/aer_reset_gen.sv | 64 ++++++
 3 files changed

// File: rtl/aer_pkg.sv
// ---------------------------------------------------------------------------
// aer_pkg
// Shared types and constants for the AER reset generator.
//   rst_mode_e   : per-channel source select (RF passthrough, periodic timer,
//                  triggered one-shot, forced reset)
//   rst_state_e  : per-channel timer FSM state
//   RST_TMR_WIDTH: default width of the interval counter / threshold
//   RST_PW_WIDTH : width of the shared pulse_width field
// ---------------------------------------------------------------------------
package aer_pkg;

  localparam int RST_TMR_WIDTH = 16;
  localparam int RST_PW_WIDTH  = 4;

  typedef enum logic [1:0] {
    MODE_RF       = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_FORCE    = 2'b11
  } rst_mode_e;

  typedef enum logic [1:0] {
    RST_IDLE  = 2'b00,
    RST_COUNT = 2'b01,
    RST_PULSE = 2'b10
  } rst_state_e;

endpackage

// File: rtl/aer_reset_chan.sv
// ---------------------------------------------------------------------------
// aer_reset_chan
// One AER reset channel: mode register, IDLE/COUNT/PULSE timer FSM, interval
// and pulse counters, and the registered active-low reset output.
// Optional feature macro: AER_RST_PULSE_CNT_EN (adds a saturating pulse counter).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            count enable (COUNT state only; PULSE ignores it)
//   mode              source select (rst_mode_e)
//   rf_aer_rst_n      regfile reset value used in MODE_RF
//   trigger           one-shot start request, sampled in IDLE
//   threshold         interval threshold
//   pulse_width       pulse length minus one, latched on PULSE entry
//   pulse_cnt_clr     (macro only) clear pulse counter
//   pulse_cnt         (macro only) saturating count of PULSE entries
//   rst_out_n         registered active-low reset output
//   busy              FSM not in IDLE
// ---------------------------------------------------------------------------
module aer_reset_chan
  import aer_pkg::*;
#(
  parameter int CNT_WIDTH = RST_TMR_WIDTH,
  parameter int PW_WIDTH  = RST_PW_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  rst_mode_e            mode,
  input  logic                 rf_aer_rst_n,
  input  logic                 trigger,
  input  logic [CNT_WIDTH-1:0] threshold,
  input  logic [PW_WIDTH-1:0]  pulse_width,
`ifdef AER_RST_PULSE_CNT_EN
  input  logic                 pulse_cnt_clr,
  output logic [7:0]           pulse_cnt,
`endif
  output logic                 rst_out_n,
  output logic                 busy
);

  rst_state_e           state_q, state_d;
  rst_mode_e            mode_q, mode_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW_WIDTH-1:0]  pw_q, pw_d;
  logic [PW_WIDTH-1:0]  pw_cnt_q, pw_cnt_d;
  logic                 out_q, out_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pw_d     = pw_q;
    pw_cnt_d = pw_cnt_q;
    mode_d   = mode;

    if (mode != mode_q) begin
      // Mode change aborts whatever was in flight, including a pulse.
      state_d  = RST_IDLE;
      cnt_d    = '0;
      pw_cnt_d = '0;
    end else if (mode == MODE_PERIODIC || mode == MODE_ONESHOT) begin
      case (state_q)
        RST_IDLE: begin
          if (mode == MODE_PERIODIC || trigger) begin
            state_d = RST_COUNT;
            cnt_d   = '0;
          end
        end
        RST_COUNT: begin
          if (enable) begin
            // >= so a threshold lowered below cnt fires at once; also
            // guarantees cnt never wraps.
            if (cnt_q >= threshold) begin
              state_d  = RST_PULSE;
              cnt_d    = '0;
              pw_d     = pulse_width;
              pw_cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        RST_PULSE: begin
          if (pw_cnt_q == pw_q) begin
            pw_cnt_d = '0;
            if (mode == MODE_PERIODIC) begin
              state_d = RST_COUNT;
              cnt_d   = '0;
            end else begin
              state_d = RST_IDLE;
            end
          end else begin
            pw_cnt_d = pw_cnt_q + 1'b1;
          end
        end
        default: state_d = RST_IDLE;
      endcase
    end else begin
      state_d = RST_IDLE;
    end

    // Output is decided from the new mode and next state, then registered.
    case (mode)
      MODE_RF:    out_d = rf_aer_rst_n;
      MODE_FORCE: out_d = 1'b0;
      default:    out_d = (state_d != RST_PULSE);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RST_IDLE;
      mode_q   <= MODE_RF;
      cnt_q    <= '0;
      pw_q     <= '0;
      pw_cnt_q <= '0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      pw_q     <= pw_d;
      pw_cnt_q <= pw_cnt_d;
      out_q    <= out_d;
    end
  end

  assign rst_out_n = out_q;
  assign busy      = (state_q != RST_IDLE);

`ifdef AER_RST_PULSE_CNT_EN
  logic       pulse_entry;
  logic [7:0] pulse_cnt_q, pulse_cnt_d;

  assign pulse_entry = (state_d == RST_PULSE) && (state_q != RST_PULSE);

  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    if (pulse_cnt_clr) begin
      pulse_cnt_d = '0;
    end else if (pulse_entry && pulse_cnt_q != 8'hFF) begin
      pulse_cnt_d = pulse_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt_q <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign pulse_cnt = pulse_cnt_q;
`endif

endmodule

// File: rtl/aer_reset_gen.sv
// ---------------------------------------------------------------------------
// aer_reset_gen
// Multi-channel AER reset generator: NUM_CH independent aer_reset_chan
// instances sharing clk, rst_n and pulse_width.
// Optional feature macro: AER_RST_PULSE_CNT_EN (pulse_cnt_clr / pulse_cnt).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          per-channel count enable
//   mode            per-channel mode (rst_mode_e)
//   rf_aer_rst_n    per-channel regfile reset (MODE_RF)
//   trigger         per-channel one-shot request
//   threshold       per-channel interval threshold
//   pulse_width     shared pulse length minus one
//   pulse_cnt_clr   (macro only) clear all pulse counters
//   pulse_cnt       (macro only) per-channel saturating pulse counts
//   rst_out_n       per-channel registered active-low AER reset
//   busy            per-channel FSM not idle
// ---------------------------------------------------------------------------
module aer_reset_gen
  import aer_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = RST_TMR_WIDTH,
  parameter int PW_WIDTH  = RST_PW_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0]                enable,
  input  rst_mode_e [NUM_CH-1:0]           mode,
  input  logic [NUM_CH-1:0]                rf_aer_rst_n,
  input  logic [NUM_CH-1:0]                trigger,
  input  logic [NUM_CH-1:0][CNT_WIDTH-1:0] threshold,
  input  logic [PW_WIDTH-1:0]              pulse_width,
`ifdef AER_RST_PULSE_CNT_EN
  input  logic                             pulse_cnt_clr,
  output logic [NUM_CH-1:0][7:0]           pulse_cnt,
`endif
  output logic [NUM_CH-1:0]                rst_out_n,
  output logic [NUM_CH-1:0]                busy
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    aer_reset_chan #(
      .CNT_WIDTH (CNT_WIDTH),
      .PW_WIDTH  (PW_WIDTH)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable[gi]),
      .mode         (mode[gi]),
      .rf_aer_rst_n (rf_aer_rst_n[gi]),
      .trigger      (trigger[gi]),
      .threshold    (threshold[gi]),
      .pulse_width  (pulse_width),
`ifdef AER_RST_PULSE_CNT_EN
      .pulse_cnt_clr(pulse_cnt_clr),
      .pulse_cnt    (pulse_cnt[gi]),
`endif
      .rst_out_n    (rst_out_n[gi]),
      .busy         (busy[gi])
    );
  end

endmodule
